// File: rtl/key_cursor_ctrl_pkg.sv
// Shared scan codes, key_event field positions, direction/state encodings
// and the single-axis step helper for the key cursor controller.
package cursor_pkg;

    localparam int KE_STROBE   = 10;
    localparam int KE_BREAK    = 9;
    localparam int KE_EXT      = 8;
    localparam int KE_CODE_MSB = 7;

    localparam logic [7:0] SC_UP_E0    = 8'h75;
    localparam logic [7:0] SC_DOWN_E0  = 8'h72;
    localparam logic [7:0] SC_LEFT_E0  = 8'h6B;
    localparam logic [7:0] SC_RIGHT_E0 = 8'h74;
    localparam logic [7:0] SC_W        = 8'h1D;
    localparam logic [7:0] SC_S        = 8'h1B;
    localparam logic [7:0] SC_A        = 8'h1C;
    localparam logic [7:0] SC_D        = 8'h23;
    localparam logic [7:0] SC_SPACE    = 8'h29;
    localparam logic [7:0] SC_ENTER    = 8'h5A;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Returns {moved, new_pos}; at an edge either saturates (moved = 0) or wraps.
    function automatic logic [4:0] step_pos(input logic [3:0] pos, input logic dec,
                                            input int unsigned lim, input logic wrap);
        logic [4:0] r;
        r = {1'b0, pos};
        if (dec) begin
            if (pos != 4'd0)
                r = {1'b1, pos - 4'd1};
            else if (wrap)
                r = {1'b1, 4'(lim - 1)};
        end else begin
            if (pos != 4'(lim - 1))
                r = {1'b1, pos + 4'd1};
            else if (wrap)
                r = {1'b1, 4'd0};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_cursor_ctrl_if.sv
// Key event input and cursor outputs between Keyboard, this controller and Play.
interface key_cursor_ctrl_if;
    logic [10:0] key_event;
    logic [3:0]  cursor_x;
    logic [3:0]  cursor_y;
    logic        is_pressed;
    logic        cursor_moved;

    modport master (output key_event, input cursor_x, cursor_y, is_pressed, cursor_moved);
    modport slave  (input key_event, output cursor_x, cursor_y, is_pressed, cursor_moved);
endinterface

// File: rtl/key_cursor_ctrl_decode.sv
// Combinational scan-code decode: key_event -> direction / select / make flags.
module key_decode
    import cursor_pkg::*;
(
    input  logic [10:0] key_event,
    output logic        is_dir,
    output dir_t        dir,
    output logic        is_sel,
    output logic        is_make
);
    logic       strobe;
    logic       ext;
    logic [7:0] code;

    assign strobe  = key_event[KE_STROBE];
    assign ext     = key_event[KE_EXT];
    assign code    = key_event[KE_CODE_MSB:0];
    assign is_make = strobe & ~key_event[KE_BREAK];

    always_comb begin
        is_dir = 1'b0;
        dir    = DIR_UP;
        is_sel = 1'b0;
        if (strobe) begin
            if (ext) begin
                case (code)
                    SC_UP_E0:    begin is_dir = 1'b1; dir = DIR_UP;    end
                    SC_DOWN_E0:  begin is_dir = 1'b1; dir = DIR_DOWN;  end
                    SC_LEFT_E0:  begin is_dir = 1'b1; dir = DIR_LEFT;  end
                    SC_RIGHT_E0: begin is_dir = 1'b1; dir = DIR_RIGHT; end
                    SC_ENTER:    is_sel = 1'b1;
                    default:     ;
                endcase
            end else begin
                case (code)
                    SC_W:     begin is_dir = 1'b1; dir = DIR_UP;    end
                    SC_S:     begin is_dir = 1'b1; dir = DIR_DOWN;  end
                    SC_A:     begin is_dir = 1'b1; dir = DIR_LEFT;  end
                    SC_D:     begin is_dir = 1'b1; dir = DIR_RIGHT; end
                    SC_SPACE: is_sel = 1'b1;
                    SC_ENTER: is_sel = 1'b1;
                    default:  ;
                endcase
            end
        end
    end
endmodule

// File: rtl/key_cursor_ctrl.sv
// Key-to-cursor controller with hold-to-repeat and debounced select pulse.
//   state  | meaning
//   IDLE   | no direction held
//   DELAY  | direction held, waiting REPEAT_DELAY cycles for first auto-repeat
//   REPEAT | direction held, auto-repeating every REPEAT_PERIOD cycles
module key_cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int BOARD_W       = 8,
    parameter int BOARD_H       = 8,
    parameter int INIT_X        = 0,
    parameter int INIT_Y        = 0,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 8_000_000,
    parameter int WRAP          = 0
) (
    input logic              clk,
    input logic              rst,
    key_cursor_ctrl_if.slave bus
);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic WRAP_EN = (WRAP != 0);

    logic             is_dir, is_sel, is_make;
    dir_t             ev_dir;

    state_t           state_q, state_d;
    dir_t             held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_held_q, sel_held_d;
    logic [3:0]       x_q, y_q, x_d, y_d;
    logic             pressed_q, pressed_d;
    logic             moved_q, moved_d;
    logic             expired;
    logic             do_move;
    dir_t             move_dir;
    logic [4:0]       step;

    key_decode u_decode (
        .key_event (bus.key_event),
        .is_dir    (is_dir),
        .dir       (ev_dir),
        .is_sel    (is_sel),
        .is_make   (is_make)
    );

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        cnt_d    = '0;
        do_move  = 1'b0;
        move_dir = held_q;
        expired  = ((state_q == DELAY)  && (cnt_q == CNT_W'(REPEAT_DELAY - 1))) ||
                   ((state_q == REPEAT) && (cnt_q == CNT_W'(REPEAT_PERIOD - 1)));

        case (state_q)
            IDLE: begin
                if (is_dir && is_make) begin
                    do_move  = 1'b1;
                    move_dir = ev_dir;
                    held_d   = ev_dir;
                    state_d  = DELAY;
                end
            end
            DELAY, REPEAT: begin
                cnt_d = cnt_q + 1'b1;
                // Releasing the held key wins over a same-cycle timer expiry.
                if (is_dir && !is_make && (ev_dir == held_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (is_dir && is_make && (ev_dir != held_q)) begin
                    do_move  = 1'b1;
                    move_dir = ev_dir;
                    held_d   = ev_dir;
                    state_d  = DELAY;
                    cnt_d    = '0;
                end else if (expired) begin
                    do_move = 1'b1;
                    state_d = REPEAT;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        moved_d = 1'b0;
        step    = '0;
        if (do_move) begin
            case (move_dir)
                DIR_UP: begin
                    step = step_pos(y_q, 1'b1, BOARD_H, WRAP_EN);
                    y_d  = step[3:0];
                end
                DIR_DOWN: begin
                    step = step_pos(y_q, 1'b0, BOARD_H, WRAP_EN);
                    y_d  = step[3:0];
                end
                DIR_LEFT: begin
                    step = step_pos(x_q, 1'b1, BOARD_W, WRAP_EN);
                    x_d  = step[3:0];
                end
                default: begin
                    step = step_pos(x_q, 1'b0, BOARD_W, WRAP_EN);
                    x_d  = step[3:0];
                end
            endcase
            moved_d = step[4];
        end
    end

    always_comb begin
        sel_held_d = sel_held_q;
        pressed_d  = 1'b0;
        if (is_sel && is_make && !sel_held_q) begin
            pressed_d  = 1'b1;
            sel_held_d = 1'b1;
        end else if (is_sel && !is_make) begin
            sel_held_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            held_q     <= DIR_UP;
            cnt_q      <= '0;
            sel_held_q <= 1'b0;
            x_q        <= 4'(INIT_X);
            y_q        <= 4'(INIT_Y);
            pressed_q  <= 1'b0;
            moved_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            sel_held_q <= sel_held_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pressed_q  <= pressed_d;
            moved_q    <= moved_d;
        end
    end

    assign bus.cursor_x     = x_q;
    assign bus.cursor_y     = y_q;
    assign bus.is_pressed   = pressed_q;
    assign bus.cursor_moved = moved_q;
endmodule
